sensor_scheduler: RTL and testbench

//  Round-robin sequencer for NUM_SENSORS HC-SR04 ultrasonic channels sharing one sensor_driver.

---
 rtl/sensor_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sensor_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: round-robin sequencer for NUM_SENSORS ultrasonic channels
// that share one sensor_driver. Each channel is started, then the block waits
// for the measurement or a timeout, stores the result, and holds a dead-time
// gap before moving to the next channel.
// Optional feature macro: NEAREST_EN adds o_nearest_dist/o_nearest_idx, the
// closest valid reading, refreshed on every sweep_done.
module sensor_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int DIST_W         = 8,
  parameter int TIMEOUT_CYCLES = 1_900_000,
  parameter int GAP_CYCLES     = 3_000_000,
  localparam int SEL_W         = $clog2(NUM_SENSORS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_run,
  input  logic                          i_single,
  input  logic                          i_meas_done,
  input  logic [DIST_W-1:0]             i_meas_dist,
  output logic                          o_drv_start,
  output logic [SEL_W-1:0]              o_sel,
  output logic [NUM_SENSORS*DIST_W-1:0] o_dist_flat,
  output logic [NUM_SENSORS-1:0]        o_dist_valid,
  output logic [NUM_SENSORS-1:0]        o_timeout_flag,
  output logic                          o_sweep_done,
  output logic                          o_busy
`ifdef NEAREST_EN
  ,
  output logic [DIST_W-1:0]             o_nearest_dist,
  output logic [SEL_W-1:0]              o_nearest_idx
`endif
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t                          r_state;
  logic [TMR_W-1:0]                r_timer;
  logic [SEL_W-1:0]                r_sel;
  logic                            r_single_pend;
  logic                            r_drv_start;
  logic                            r_sweep_done;
  logic                            r_busy;
  logic [NUM_SENSORS*DIST_W-1:0]   r_dist_flat;
  logic [NUM_SENSORS-1:0]          r_dist_valid;
  logic [NUM_SENSORS-1:0]          r_timeout_flag;

  logic w_last_ch;
  logic w_wait_expired;
  logic w_gap_done;

  assign w_last_ch      = (r_sel == SEL_W'(NUM_SENSORS - 1));
  assign w_wait_expired = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign w_gap_done     = (r_timer == TMR_W'(GAP_CYCLES - 1));

  // Scan FSM: channel select, driver start pulse, result capture and gap timing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_sel          <= '0;
      r_single_pend  <= 1'b0;
      r_drv_start    <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_busy         <= 1'b0;
      // NOTE: the distance bank is plain flops, not a RAM, because reset must
      // clear every slot; a memory macro could not be cleared in one cycle.
      r_dist_flat    <= '0;
      r_dist_valid   <= '0;
      r_timeout_flag <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in the
      // same cycle override these pulse defaults without ordering hazards.
      r_drv_start  <= 1'b0;
      r_sweep_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run || i_single) begin
            r_state     <= S_START;
            r_drv_start <= 1'b1;
            r_busy      <= 1'b1;
            if (i_single) r_single_pend <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_timer <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (i_meas_done) begin
            r_dist_flat[int'(r_sel)*DIST_W +: DIST_W] <= i_meas_dist;
            r_dist_valid[r_sel]   <= 1'b1;
            r_timeout_flag[r_sel] <= 1'b0;
            r_state               <= S_GAP;
            r_timer               <= '0;
          end else if (w_wait_expired) begin
            r_dist_flat[int'(r_sel)*DIST_W +: DIST_W] <= {DIST_W{1'b1}};
            r_dist_valid[r_sel]   <= 1'b0;
            r_timeout_flag[r_sel] <= 1'b1;
            r_state               <= S_GAP;
            r_timer               <= '0;
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_timer <= '0;
            if (w_last_ch) begin
              r_sel         <= '0;
              r_sweep_done  <= 1'b1;
              r_single_pend <= 1'b0;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
            // A pending single sweep continues only until the wrap.
            if (i_run || (r_single_pend && !w_last_ch)) begin
              r_state     <= S_START;
              r_drv_start <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_drv_start    = r_drv_start;
  assign o_sel          = r_sel;
  assign o_dist_flat    = r_dist_flat;
  assign o_dist_valid   = r_dist_valid;
  assign o_timeout_flag = r_timeout_flag;
  assign o_sweep_done   = r_sweep_done;
  assign o_busy         = r_busy;

`ifdef NEAREST_EN
  logic [DIST_W-1:0] w_min_dist;
  logic [SEL_W-1:0]  w_min_idx;
  logic              w_min_found;
  logic [DIST_W-1:0] r_nearest_dist;
  logic [SEL_W-1:0]  r_nearest_idx;

  // Minimum search over valid slots; strict compare keeps the lowest index on ties.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_min_dist  = {DIST_W{1'b1}};
    w_min_idx   = '0;
    w_min_found = 1'b0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (r_dist_valid[i] &&
          (!w_min_found || (r_dist_flat[i*DIST_W +: DIST_W] < w_min_dist))) begin
        w_min_dist  = r_dist_flat[i*DIST_W +: DIST_W];
        w_min_idx   = SEL_W'(i);
        w_min_found = 1'b1;
      end
    end
  end

  // Latch the nearest reading once per completed sweep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nearest_dist <= {DIST_W{1'b1}};
      r_nearest_idx  <= '0;
    end else if (r_sweep_done) begin
      r_nearest_dist <= w_min_dist;
      r_nearest_idx  <= w_min_idx;
    end
  end

  assign o_nearest_dist = r_nearest_dist;
  assign o_nearest_idx  = r_nearest_idx;
`endif

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed testbench for sensor_scheduler (NUM_SENSORS=4, TIMEOUT_CYCLES=20,
// GAP_CYCLES=5). A behavioural driver model answers each start pulse after a
// programmable delay; stimulus changes on the falling edge, outputs are
// sampled on the falling edge.
module tb_sensor_scheduler;

  localparam int NS = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic            run;
  logic            single;
  logic            meas_done;
  logic [DW-1:0]   meas_dist;
  logic            drv_start;
  logic [1:0]      sel;
  logic [NS*DW-1:0] dist_flat;
  logic [NS-1:0]   dist_valid;
  logic [NS-1:0]   timeout_flag;
  logic            sweep_done;
  logic            busy;
`ifdef NEAREST_EN
  logic [DW-1:0]   nearest_dist;
  logic [1:0]      nearest_idx;
`endif

  sensor_scheduler #(
    .NUM_SENSORS(NS), .DIST_W(DW), .TIMEOUT_CYCLES(20), .GAP_CYCLES(5)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_single(single),
    .i_meas_done(meas_done), .i_meas_dist(meas_dist),
    .o_drv_start(drv_start), .o_sel(sel), .o_dist_flat(dist_flat),
    .o_dist_valid(dist_valid), .o_timeout_flag(timeout_flag),
    .o_sweep_done(sweep_done), .o_busy(busy)
`ifdef NEAREST_EN
    , .o_nearest_dist(nearest_dist), .o_nearest_idx(nearest_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Driver-model knobs (written only by the test process).
  logic [NS-1:0] ans_mask;
  int            resp_delay;
  logic [DW-1:0] resp_val [NS];

  // Model bookkeeping (written only by the model process).
  int            cyc = 0;
  int            start_cnt = 0;
  int            sweep_cnt = 0;
  int            start_t[$];

  // Sensor-driver model: answers a start pulse resp_delay cycles later.
  initial begin : driver_model
    int            cnt;
    logic [DW-1:0] pend;
    cnt = 0;
    pend = '0;
    meas_done = 1'b0;
    meas_dist = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      meas_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          meas_done = 1'b1;
          meas_dist = pend;
        end
      end
      if (drv_start === 1'b1) begin
        start_cnt++;
        start_t.push_back(cyc);
        if (ans_mask[sel]) begin
          cnt  = resp_delay;
          pend = resp_val[sel];
        end
      end
      if (sweep_done === 1'b1) sweep_cnt++;
    end
  end

  task automatic set_vals(input logic [DW-1:0] a, b, c, d);
    resp_val[0] = a; resp_val[1] = b; resp_val[2] = c; resp_val[3] = d;
  endtask

  task automatic wait_sweeps(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (sweep_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (sweep_cnt < target) begin
      n_bad++;
      $display("FAIL %s: sweeps seen %0d, required %0d within %0d cycles", name, sweep_cnt, target, budget);
    end
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (start_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (start_cnt < target) begin
      n_bad++;
      $display("FAIL %s: starts seen %0d, required %0d within %0d cycles", name, start_cnt, target, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < budget);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; single = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", sel); end
    n_cmp++; if (drv_start !== 1'b0) begin n_bad++; $display("FAIL reset_drv_start: got %b want 0", drv_start); end
    n_cmp++; if (dist_flat !== 32'h0) begin n_bad++; $display("FAIL reset_dist: got %h want 0", dist_flat); end
    n_cmp++; if (dist_valid !== 4'h0 || timeout_flag !== 4'h0 || sweep_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: valid %b tflag %b sweep %b want 0", dist_valid, timeout_flag, sweep_done); end
`ifdef NEAREST_EN
    n_cmp++; if (nearest_dist !== 8'hFF || nearest_idx !== 2'd0) begin
      n_bad++; $display("FAIL reset_nearest: got %h/%0d want ff/0", nearest_dist, nearest_idx); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_sweep();
    int s0, w0;
    ans_mask = 4'hF; resp_delay = 3; set_vals(8'd10, 8'd20, 8'd30, 8'd40);
    s0 = start_cnt; w0 = sweep_cnt;
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    n_cmp++; if (drv_start !== 1'b1 || sel !== 2'd0) begin
      n_bad++; $display("FAIL single_latency: drv_start %b sel %0d want 1/0", drv_start, sel); end
    wait_sweeps(w0 + 1, 100, "single_sweep_done");
    repeat (20) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 4) begin n_bad++; $display("FAIL single_starts: got %0d want 4", start_cnt - s0); end
    n_cmp++; if (sweep_cnt - w0 !== 1) begin n_bad++; $display("FAIL single_sweeps: got %0d want 1", sweep_cnt - w0); end
    n_cmp++; if (dist_flat !== 32'h281E140A) begin n_bad++; $display("FAIL single_dist: got %h want 281e140a", dist_flat); end
    n_cmp++; if (dist_valid !== 4'hF || timeout_flag !== 4'h0) begin
      n_bad++; $display("FAIL single_flags: valid %b tflag %b want 1111/0000", dist_valid, timeout_flag); end
    n_cmp++; if (busy !== 1'b0 || sel !== 2'd0) begin
      n_bad++; $display("FAIL single_idle: busy %b sel %0d want 0/0", busy, sel); end
  endtask

  task automatic test_timeout();
    int b0, sp;
    ans_mask = 4'b1011; resp_delay = 3; set_vals(8'd11, 8'd22, 8'd33, 8'd44);
    b0 = start_t.size();
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    wait_sweeps(sweep_cnt + 1, 150, "timeout_sweep_done");
    repeat (3) @(negedge clk);
    n_cmp++; if (start_t.size() - b0 !== 4) begin
      n_bad++; $display("FAIL timeout_starts: got %0d want 4", start_t.size() - b0); end
    else begin
      sp = start_t[b0 + 3] - start_t[b0 + 2];
      n_cmp++; if (sp !== 26) begin n_bad++; $display("FAIL timeout_wait_len: start spacing %0d want 26", sp); end
      sp = start_t[b0 + 1] - start_t[b0];
      n_cmp++; if (sp !== 9) begin n_bad++; $display("FAIL timeout_normal_len: start spacing %0d want 9", sp); end
    end
    n_cmp++; if (dist_flat !== 32'h2CFF160B) begin n_bad++; $display("FAIL timeout_dist: got %h want 2cff160b", dist_flat); end
    n_cmp++; if (timeout_flag !== 4'b0100) begin n_bad++; $display("FAIL timeout_flag: got %b want 0100", timeout_flag); end
    n_cmp++; if (dist_valid !== 4'b1011) begin n_bad++; $display("FAIL timeout_valid: got %b want 1011", dist_valid); end
  endtask

  task automatic test_back_to_back();
    int s0, w0, b0, bad_sp;
    ans_mask = 4'hF; resp_delay = 3; set_vals(8'd1, 8'd2, 8'd3, 8'd4);
    s0 = start_cnt; w0 = sweep_cnt; b0 = start_t.size();
    run = 1'b1;
    wait_starts(s0 + 12, 200, "run_twelve_starts");
    run = 1'b0;
    wait_sweeps(w0 + 3, 100, "run_three_sweeps");
    repeat (20) @(negedge clk);
    n_cmp++; if (start_cnt - s0 !== 12) begin n_bad++; $display("FAIL run_starts: got %0d want 12", start_cnt - s0); end
    n_cmp++; if (sweep_cnt - w0 !== 3) begin n_bad++; $display("FAIL run_sweeps: got %0d want 3", sweep_cnt - w0); end
    bad_sp = 0;
    for (int i = b0 + 1; i < start_t.size(); i++)
      if (start_t[i] - start_t[i-1] != 9) bad_sp++;
    n_cmp++; if (bad_sp !== 0) begin n_bad++; $display("FAIL run_spacing: %0d intervals differ from 9", bad_sp); end
    n_cmp++; if (dist_flat !== 32'h04030201 || timeout_flag !== 4'h0) begin
      n_bad++; $display("FAIL run_dist: got %h tflag %b want 04030201/0000", dist_flat, timeout_flag); end
    n_cmp++; if (busy !== 1'b0 || sel !== 2'd0) begin
      n_bad++; $display("FAIL run_idle: busy %b sel %0d want 0/0", busy, sel); end
  endtask

  task automatic test_run_drop();
    int s0;
    ans_mask = 4'hF; resp_delay = 3; set_vals(8'd5, 8'd6, 8'd7, 8'd8);
    s0 = start_cnt;
    run = 1'b1;
    wait_starts(s0 + 2, 50, "drop_second_start");
    @(negedge clk);
    run = 1'b0;
    wait_idle(50, "drop_idle");
    n_cmp++; if (sel !== 2'd2 || start_cnt - s0 !== 2) begin
      n_bad++; $display("FAIL drop_sel: sel %0d starts %0d want 2/2", sel, start_cnt - s0); end
    n_cmp++; if (dist_flat[15:0] !== 16'h0605) begin n_bad++; $display("FAIL drop_dist: got %h want 0605", dist_flat[15:0]); end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n_cmp++; if (drv_start !== 1'b1 || sel !== 2'd2) begin
      n_bad++; $display("FAIL resume_sel: drv_start %b sel %0d want 1/2", drv_start, sel); end
    wait_idle(50, "resume_idle");
    n_cmp++; if (sel !== 2'd3 || dist_flat !== 32'h04070605) begin
      n_bad++; $display("FAIL resume_result: sel %0d dist %h want 3/04070605", sel, dist_flat); end
  endtask

  task automatic test_reset_mid();
    int s0;
    ans_mask = 4'hF; resp_delay = 4; set_vals(8'd9, 8'd9, 8'd9, 8'd9);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    n_cmp++; if (busy !== 1'b0 || sel !== 2'd0 || drv_start !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_ctrl: busy %b sel %0d drv_start %b want 0/0/0", busy, sel, drv_start); end
    n_cmp++; if (dist_flat !== 32'h0 || dist_valid !== 4'h0 || timeout_flag !== 4'h0) begin
      n_bad++; $display("FAIL rstmid_data: dist %h valid %b tflag %b want 0", dist_flat, dist_valid, timeout_flag); end
    repeat (10) @(negedge clk);
    n_cmp++; if (dist_flat !== 32'h0 || dist_valid !== 4'h0) begin
      n_bad++; $display("FAIL rstmid_meas_ignored: dist %h valid %b want 0/0", dist_flat, dist_valid); end
    n_cmp++; if (start_cnt !== s0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_no_start: extra starts %0d busy %b want 0/0", start_cnt - s0, busy); end
  endtask

`ifdef NEAREST_EN
  task automatic test_nearest();
    ans_mask = 4'hF; resp_delay = 3; set_vals(8'd50, 8'd12, 8'd12, 8'd90);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    wait_sweeps(sweep_cnt + 1, 100, "nearest_sweep_done");
    repeat (3) @(negedge clk);
    n_cmp++; if (nearest_dist !== 8'd12 || nearest_idx !== 2'd1) begin
      n_bad++; $display("FAIL nearest: got %0d/%0d want 12/1", nearest_dist, nearest_idx); end
  endtask
`endif

  initial begin
    rst = 1'b1; run = 1'b0; single = 1'b0;
    ans_mask = 4'hF; resp_delay = 3; set_vals(8'd0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_single_sweep();
    test_timeout();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
`ifdef NEAREST_EN
    test_nearest();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
